// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single-port instruction/data RAM. Each granted
// access occupies two cycles: the issue cycle and the completion cycle.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_IF = 2'd1;
  localparam logic [1:0] S_WAIT_D  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             in_idle;
  logic             starved;
  logic             grant_d;
  logic             grant_if;

  always_comb begin
    // Reset suppresses both new grants and any in-flight completion pulse.
    in_idle  = ~rst && (state_q == S_IDLE);
    starved  = if_req && (starve_cnt_q == STARVE_LIM);
    grant_d  = in_idle && d_req && ~starved;
    grant_if = in_idle && if_req && ~grant_d;

    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = 4'h0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (grant_if) begin
      ram_en   = 1'b1;
      ram_be   = 4'hF;
      ram_addr = if_addr;
    end else if (grant_d) begin
      ram_en    = 1'b1;
      ram_we    = d_we;
      ram_be    = d_we ? d_be : 4'hF;
      ram_addr  = d_addr;
      ram_wdata = d_we ? d_wdata : '0;
    end

    if_valid = ~rst && (state_q == S_WAIT_IF);
    d_valid  = ~rst && (state_q == S_WAIT_D);
    if_rdata = if_valid ? ram_rdata : '0;
    d_rdata  = d_valid ? ram_rdata : '0;
    if_stall = if_req & ~if_valid;
    d_stall  = d_req & ~d_valid;

    state_d = S_IDLE;
    if (grant_if) state_d = S_WAIT_IF;
    else if (grant_d) state_d = S_WAIT_D;

    // Counts data grants that overtook a waiting fetch; any gap in if_req resets it.
    starve_cnt_d = starve_cnt_q;
    if (state_q == S_IDLE) begin
      if (!if_req || grant_if) begin
        starve_cnt_d = '0;
      end else if (grant_d && (starve_cnt_q != STARVE_LIM)) begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
    end
  end

  // Control registers only
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-port synchronous data/instruction RAM between the instruction-fetch port and the memory-stage load/store port. Sits between the fetch and memory pipeline stages and the RAM macro. Issues one RAM access per two cycles and returns read data with a one-cycle valid pulse. Produces per-port stall signals for the pipeline controller and bounds fetch starvation with a counter.

## Interface
- ADDR_W, 32, RAM byte-address width
- DATA_W, 32, RAM data width; 4 byte lanes
- STARVE_MAX, 4, consecutive data grants tolerated while a fetch is pending; must be ≥1, counter width $clog2(STARVE_MAX+1)

- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  fetch request; held with if_addr until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch data; equals ram_rdata while if_valid, else 0
- if_valid  out  1  one-cycle fetch completion pulse
- if_stall  out  1  if_req & ~if_valid
- d_req  in  1  load/store request; held with d_we/d_addr/d_wdata/d_be until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  load/store address
- d_wdata  in  DATA_W  store data, already lane-aligned
- d_be  in  4  store byte enables
- d_rdata  out  DATA_W  load data; equals ram_rdata while d_valid, else 0
- d_valid  out  1  one-cycle completion pulse (load data or store ack)
- d_stall  out  1  d_req & ~d_valid
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_be  out  4  RAM byte enables
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en with ram_we=0

## Operation
- States: IDLE, WAIT_IF, WAIT_D (registered). starve_cnt registered.
- IDLE, no req: all ram_* outputs 0, state stays IDLE.
- IDLE, grant decision (combinational, same cycle): grant D if d_req & ~(if_req & starve_cnt==STARVE_MAX); else grant IF if if_req.
- Grant IF: ram_en=1, ram_we=0, ram_be=4'hF, ram_addr=if_addr, ram_wdata=0; next WAIT_IF.
- Grant D: ram_en=1, ram_we=d_we, ram_be = d_we ? d_be : 4'hF, ram_addr=d_addr, ram_wdata = d_we ? d_wdata : 0; next WAIT_D.
- Store with d_be==0: issued unchanged (ram_we=1, ram_be=0); RAM writes nothing; d_valid still pulses.
- WAIT_IF: if_valid=1, ram_* outputs 0, next IDLE. WAIT_D: d_valid=1, ram_* outputs 0, next IDLE.
- No grant in WAIT states; a requester's held req during its valid cycle is never re-served.
- starve_cnt: +1 (saturating at STARVE_MAX) on each D grant while if_req=1; cleared on IF grant or whenever if_req=0 in IDLE; unchanged otherwise.
- Ports are independent; no address comparison or forwarding between them.

## Timing
- Reset (rst=1 at edge): state=IDLE, starve_cnt=0. Outputs while in IDLE with no req: ram_en/ram_we/ram_be/ram_addr/ram_wdata=0, if_valid/d_valid=0, if_rdata/d_rdata=0, stalls follow req.
- Reset mid-access (state WAIT_x): next cycle IDLE, the pending valid pulse is lost; requester keeps req and is re-served.
- Latency: request seen in IDLE at cycle T → ram_en at T → x_valid at T+1. Throughput: one access per 2 cycles.
- Both req at T, count below limit: D granted T, valid T+1; IF granted T+2, valid T+3.
- Requester may change address/req in the cycle after valid; new request sampled only in IDLE.
- Stalls are combinational from req and valid; no registered delay.

## Test plan
- Reset: rst=1 two cycles with if_req=d_req=1 → all ram_* 0, no valid; rst low → D granted first cycle, ram_en=1.
- Single load: d_req, d_we=0, d_addr=0x100, RAM returns 0xDEADBEEF → ram_be=4'hF at T, d_valid=1 and d_rdata=0xDEADBEEF at T+1, d_stall=0 at T+1.
- Store: d_we=1, d_addr=0x204, d_be=4'b0011, d_wdata=0x0000ABCD → ram_we=1, ram_be=4'b0011, ram_wdata=0x0000ABCD at T; d_valid at T+1; RAM word 0x204 low half updated only.
- Contention/starvation, STARVE_MAX=4: if_req and d_req held continuously → grant sequence D,D,D,D,IF,D,D,D,D,IF…; if_valid every 10 cycles.
- Fetch-only stream: if_req continuous, addresses 0,4,8 → if_valid at T+1,T+3,T+5 with matching data; d_valid never asserted.
- Reset in WAIT_D: load granted at T, rst=1 at T+1 edge → no d_valid; after rst low, load re-issued, d_valid with correct data two cycles later.
